// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined FP multiplier.
// Operand classes, flag bit positions, bias and canonical QNaN.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_SUB  = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_cls_e;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // LSB-aligned in a wide vector; callers keep the low FP_W bits
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Normalise, round-to-nearest-even and pack a significand product.
// FP_MUL_SUBNORMAL_EN adds the leading-zero normaliser and denormal shifter.
module fp_round_norm
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int FP_W = 1 + EXP_W + MAN_W,
    localparam int PW = 2 * MAN_W + 2
) (
    input  logic                    i_sign,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [PW-1:0]           i_prod,
    input  fp_cls_e                 i_cls,
    output logic [FP_W-1:0]         o_res,
    output logic [3:0]              o_flags
);

    localparam logic [127:0] QNAN_X = fp_qnan(EXP_W, MAN_W);
    localparam logic [FP_W-1:0] QNAN = QNAN_X[FP_W-1:0];
    localparam int EMAX = (1 << EXP_W) - 1;

    int               w_en;
    int               w_er;
    logic [PW-1:0]    w_norm;
    logic [MAN_W:0]   w_mant;
    logic [MAN_W+1:0] w_mr;
    logic             w_g;
    logic             w_s;
    logic             w_stk;
    logic             w_rup;
    logic             w_tiny;
    logic             w_nx;
    logic             w_flush;
    logic             w_uf;
`ifdef FP_MUL_SUBNORMAL_EN
    int               w_lz;
    int               w_sh;
    logic             w_found;
`endif

    always_comb begin
        w_en  = int'(i_exp) + 1;
        w_stk = 1'b0;
`ifdef FP_MUL_SUBNORMAL_EN
        w_lz    = 0;
        w_found = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (i_prod[i]) w_found = 1'b1;
                else           w_lz = w_lz + 1;
            end
        end
        w_norm = i_prod << w_lz;
        w_en   = w_en - w_lz;
        w_tiny = (w_en < 1);
        w_sh   = 0;
        // Tiny results drop into the subnormal field (exponent code 0)
        if (w_tiny) begin
            w_sh   = (1 - w_en > PW) ? PW : 1 - w_en;
            w_stk  = |(w_norm & ~({PW{1'b1}} << w_sh));
            w_norm = w_norm >> w_sh;
            w_en   = 0;
        end
        w_flush = 1'b0;
`else
        w_norm = i_prod[PW-1] ? i_prod : i_prod << 1;
        if (!i_prod[PW-1]) w_en = w_en - 1;
        w_tiny  = (w_en < 1);
        w_flush = w_tiny;
`endif
        w_mant = w_norm[PW-1 -: MAN_W+1];
        w_g    = w_norm[MAN_W];
        w_s    = (|w_norm[MAN_W-1:0]) | w_stk;
        w_rup  = w_g & (w_s | w_mant[0]);
        w_mr   = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_rup};
        w_er   = w_en;
        if (w_mr[MAN_W+1]) begin
            w_mr = w_mr >> 1;
            w_er = w_er + 1;
        end else if (w_er == 0 && w_mr[MAN_W]) begin
            w_er = 1;
        end
        w_nx = w_g | w_s;
`ifdef FP_MUL_SUBNORMAL_EN
        w_uf = w_tiny & w_nx;
`else
        w_uf = 1'b0;
`endif

        o_res   = '0;
        o_flags = '0;
        case (i_cls)
            CLS_NAN: begin
                o_res            = QNAN;
                o_flags[FLG_INV] = 1'b1;
            end
            CLS_INF:  o_res = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: o_res = {i_sign, {(FP_W-1){1'b0}}};
            default: begin
                if (w_flush) begin
                    o_res            = {i_sign, {(FP_W-1){1'b0}}};
                    o_flags[FLG_UNF] = 1'b1;
                    o_flags[FLG_NX]  = 1'b1;
                end else if (w_er >= EMAX) begin
                    o_res            = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    o_flags[FLG_OVF] = 1'b1;
                    o_flags[FLG_NX]  = 1'b1;
                end else begin
                    o_res            = {i_sign, w_er[EXP_W-1:0], w_mr[MAN_W-1:0]};
                    o_flags[FLG_NX]  = w_nx;
                    o_flags[FLG_UNF] = w_uf;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-754-style multiplier, RNE, flags, valid/ready backpressure.
// Define FP_MUL_SUBNORMAL_EN for gradual underflow; default flushes to zero.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int FP_W = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] FP_A,
    input  logic [FP_W-1:0] FP_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] FP_out,
    output logic [3:0]      flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS = XW'(fp_bias(EXP_W));

    function automatic fp_cls_e classify(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] f
    );
        if (&e) return (|f) ? CLS_NAN : CLS_INF;
`ifdef FP_MUL_SUBNORMAL_EN
        if (e == '0) return (|f) ? CLS_SUB : CLS_ZERO;
`else
        if (e == '0) return CLS_ZERO;
`endif
        return CLS_NORM;
    endfunction

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [MAN_W:0]   w_ma, w_mb;
    logic [XW-1:0]    w_xa, w_xb, w_exp;
    fp_cls_e          w_ca, w_cb, w_cls;
    logic             w_stall;
    logic [FP_W-1:0]  w_res;
    logic [3:0]       w_flags;

    logic                 r1_valid, r2_valid, r3_valid;
    logic                 r1_sign, r2_sign;
    logic signed [XW-1:0] r1_exp, r2_exp;
    logic [MAN_W:0]       r1_ma, r1_mb;
    fp_cls_e              r1_cls, r2_cls;
    logic [PW-1:0]        r2_prod;
    logic [FP_W-1:0]      r3_out;
    logic [3:0]           r3_flags;

    assign w_stall   = r3_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r3_valid;
    assign FP_out    = r3_out;
    assign flags     = r3_flags;

    always_comb begin
        w_ea = FP_A[FP_W-2 -: EXP_W];
        w_eb = FP_B[FP_W-2 -: EXP_W];
        w_fa = FP_A[MAN_W-1:0];
        w_fb = FP_B[MAN_W-1:0];
        w_ca = classify(w_ea, w_fa);
        w_cb = classify(w_eb, w_fb);
        w_ma = {w_ca == CLS_NORM, w_fa};
        w_mb = {w_cb == CLS_NORM, w_fb};
        // Subnormals have exponent code 0 but weigh as exponent 1
        w_xa  = {2'b00, w_ea} | XW'(w_ca == CLS_SUB);
        w_xb  = {2'b00, w_eb} | XW'(w_cb == CLS_SUB);
        w_exp = w_xa + w_xb - BIAS;
        if (w_ca == CLS_NAN || w_cb == CLS_NAN
            || (w_ca == CLS_INF && w_cb == CLS_ZERO)
            || (w_ca == CLS_ZERO && w_cb == CLS_INF)) begin
            w_cls = CLS_NAN;
        end else if (w_ca == CLS_INF || w_cb == CLS_INF) begin
            w_cls = CLS_INF;
        end else if (w_ca == CLS_ZERO || w_cb == CLS_ZERO) begin
            w_cls = CLS_ZERO;
        end else begin
            w_cls = CLS_NORM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_ma    <= '0;
            r1_mb    <= '0;
            r1_cls   <= CLS_ZERO;
        end else if (!w_stall) begin
            r1_valid <= in_valid;
            r1_sign  <= FP_A[FP_W-1] ^ FP_B[FP_W-1];
            r1_exp   <= $signed(w_exp);
            r1_ma    <= w_ma;
            r1_mb    <= w_mb;
            r1_cls   <= w_cls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_exp   <= '0;
            r2_prod  <= '0;
            r2_cls   <= CLS_ZERO;
        end else if (!w_stall) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_exp   <= r1_exp;
            r2_prod  <= PW'(r1_ma) * PW'(r1_mb);
            r2_cls   <= r1_cls;
        end
    end

    fp_round_norm #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign  (r2_sign),
        .i_exp   (r2_exp),
        .i_prod  (r2_prod),
        .i_cls   (r2_cls),
        .o_res   (w_res),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_out   <= '0;
            r3_flags <= '0;
        end else if (!w_stall) begin
            r3_valid <= r2_valid;
            r3_out   <= w_res;
            r3_flags <= w_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32 configuration).
// Directed vectors; a negedge monitor checks results, latency and stalls.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] FP_A = '0;
    logic [31:0] FP_B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] FP_out;
    logic [3:0]  flags;

    fp_mul_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .FP_A      (FP_A),
        .FP_B      (FP_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .FP_out    (FP_out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int bp_lo = 1 << 30;
    int bp_hi = 0;
    always @(posedge clk) begin
        #2;
        out_ready = !(cyc >= bp_lo && cyc <= bp_hi);
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic bad(input string nm, input string why);
        n_chk++;
        $display("FAIL %s: %s", nm, why);
    endtask

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          tcyc;
        bit          lat;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];
    bit    front_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                bad("spurious", "out_valid with no outstanding operation");
            end else begin
                if (!front_seen) begin
                    front_seen = 1'b1;
                    if (sb[0].lat) chk({sb_nm[0], "_lat"}, 32'(cyc - sb[0].tcyc), 32'd3);
                end
                if (out_ready) begin
                    chk(sb_nm[0], FP_out, sb[0].res);
                    chk({sb_nm[0], "_flags"}, 32'(flags), 32'(sb[0].flg));
                    void'(sb.pop_front());
                    void'(sb_nm.pop_front());
                    front_seen = 1'b0;
                end else begin
                    n_stall++;
                    chk({sb_nm[0], "_hold"}, FP_out, sb[0].res);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f,
                         input string nm, input bit lat);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        FP_A     = a;
        FP_B     = b;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            bad(nm, "in_ready never rose");
            in_valid = 1'b0;
        end else begin
            e.res  = r;
            e.flg  = f;
            e.tcyc = cyc;
            e.lat  = lat;
            sb.push_back(e);
            sb_nm.push_back(nm);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            bad(nm, "results never arrived");
            sb.delete();
            sb_nm.delete();
            front_seen = 1'b0;
        end
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fp_out", FP_out, 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "basic", 1'b1);
        idle(1);
        drain("basic");

        issue(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, "rne_tie", 1'b1);
        issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rne_sq", 1'b1);
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_0", 1'b1);
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf", 1'b1);
        issue(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "ovf", 1'b1);
`ifdef FP_MUL_SUBNORMAL_EN
        issue(32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, "unf", 1'b1);
`else
        issue(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "unf", 1'b1);
`endif
        idle(1);
        drain("specials");

        s0    = cyc + 1;
        bp_lo = s0 + 4;
        bp_hi = s0 + 8;
        n_stall = 0;
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "bp0", 1'b0);
        issue(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, "bp1", 1'b0);
        issue(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, "bp2", 1'b0);
        issue(32'hBF800000, 32'h40400000, 32'hC0400000, 4'b0000, "bp3", 1'b0);
        issue(32'h3F000000, 32'h3F000000, 32'h3E800000, 4'b0000, "bp4", 1'b0);
        issue(32'h40A00000, 32'h40A00000, 32'h41C80000, 4'b0000, "bp5", 1'b0);
        idle(1);
        drain("backpressure");
        chk("stall_cycles", 32'(n_stall), 32'd5);

        @(negedge clk);
        in_valid = 1'b1;
        FP_A = 32'h3F800000;
        FP_B = 32'h40000000;
        @(negedge clk);
        FP_A = 32'h40400000;
        FP_B = 32'h40400000;
        @(negedge clk);
        FP_A = 32'h40A00000;
        FP_B = 32'h3F000000;
        rst  = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        idle(6);

        issue(32'h3FC7AE14, 32'h3F9D70A4, 32'h3FF59B3D, 4'b0001, "golden", 1'b1);
        idle(1);
        drain("golden");
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor to the combinational MUT multiplier.
- Adds configurable exponent and mantissa widths, round-to-nearest-even, exception flags, and a valid/ready handshake with backpressure.
- Sits in the RNN accelerator datapath between operand fetch and the accumulator/activation stage.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived, not overridable: FP_W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- FP_A  in  FP_W  operand A {sign, exp, frac}.
- FP_B  in  FP_W  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- FP_out  out  FP_W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with FP_out.

Behaviour:
- Reset: synchronous, active-high. All stage valid bits cleared, FP_out=0, flags=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight operand. No output is produced for them.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline: 3 registered stages, latency exactly 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 per cycle.
  - S1: unpack; classify zero/inf/NaN/subnormal; sign = A.s ^ B.s; exponent sum = eA+eB-bias, signed, width EXP_W+2.
  - S2: (MAN_W+1)x(MAN_W+1) significand product, width 2*MAN_W+2.
  - S3: normalise (shift right by 1 if MSB set, exp+1); RNE using guard bit plus sticky OR of the remaining bits; a rounding carry renormalises; pack; set flags.
- Stall: stall = out_valid & ~out_ready.
  - While stall is high, all stages hold and in_ready=0.
  - Bubbles never advance while stalled; no compaction.
  - FP_out and flags stay stable while out_valid=1 and out_ready=0.
- Simultaneous input and output transfer in the same cycle is legal and sustains full rate.
- Specials, in priority order:
  - NaN operand or inf*0 → canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - inf operand → signed inf.
  - zero operand → signed zero.
- Overflow: rounded exponent ≥ all-ones → signed inf, overflow=1, inexact=1.
- Underflow: handled per the optional feature below.
- inexact=1 whenever any discarded bit is nonzero.
- No internal state beyond the pipeline registers. No counters survive a flush.

Optional Feature:
- Macro: FP_MUL_SUBNORMAL_EN.
- Defined:
  - Subnormal inputs are unpacked with hidden bit 0 and exponent 1.
  - Results below the normal range are right-shifted into subnormal form, with sticky collection, before RNE.
  - underflow=1 only if the result is tiny and inexact.
  - A rounding carry into the minimum normal yields a normal result.
- Undefined:
  - Subnormal inputs are treated as signed zero.
  - Any result with biased exponent < 1 flushes to signed zero with underflow=1 and inexact=1.
  - No denormal shifter is instantiated.

Decomposition:
- Package fp_mul_pkg holds:
  - class encoding constants (ZERO, NORM, SUB, INF, NAN);
  - flag bit indices;
  - functions for bias and the canonical QNaN pattern, parameterised by EXP_W/MAN_W.
- One sub-module is natural: fp_round_norm, the S3 combinational normalise/round/pack logic. It is reusable by the planned fp_add_pipe.

Test Plan:
- Basic: 0x3FC00000 * 0x40000000 (1.5*2.0) → 0x40400000, flags=0, out_valid exactly 3 cycles after the input transfer.
- RNE tie: 0x3F800001 * 0x3FC00000 → 0x3FC00002, inexact=1. Also 0x3F800001 * 0x3F800001 → 0x3F800002, inexact=1.
- Specials:
  - 0x7F800000 * 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 * 0x40000000 → 0xFF800000.
  - 0x7F000000 * 0x40000000 → 0x7F800000, overflow=1, inexact=1.
- Underflow: 0x00800000 * 0x3F000000 → 0x00400000, underflow=0 with FP_MUL_SUBNORMAL_EN defined; → 0x00000000, underflow=1 without it.
- Backpressure: stream 6 operand pairs with out_ready low for cycles 4–8 → in_ready drops, no result is lost or duplicated, order is preserved, FP_out is stable while stalled.
- Reset: assert rst for one cycle while 3 operations are in flight → out_valid=0 on the next cycle and none of the flushed results ever appear. Then repeat 1.56*1.23 (0x3FC7AE14 * 0x3F9D70A4) and check FP_out against the bit-exact RNE golden model.
